// File: rtl/doppler_ramp.sv
// Linear doppler ramp generator: drives the NCO phase-increment word and enable.
// Define DOPPLER_RAMP_SAT_EN to clamp signed overflow and report it on sat.
module doppler_ramp #(
    parameter int FREQ_W     = 32,
    parameter int RATE_W     = 24,
    parameter int CNT_W      = 32,
    parameter int UPDATE_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [FREQ_W-1:0] cfg_freq,
    input  logic [RATE_W-1:0] cfg_rate,
    input  logic [CNT_W-1:0]  cfg_steps,
    input  logic              start,
    input  logic              abort,
    output logic [FREQ_W-1:0] freq,
    output logic              enable,
    output logic              busy,
    output logic              done,
    output logic              sat
);
    localparam int PRE_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(UPDATE_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOADED = 2'd1,
        S_RUN    = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t              r_state, w_state;
    logic [FREQ_W-1:0]   r_freq, w_freq;
    logic                r_enable, w_enable;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic                r_sat, w_sat;
    logic                r_cfg_ready, w_cfg_ready;
    logic [FREQ_W-1:0]   r_sh_freq, w_sh_freq;
    logic [RATE_W-1:0]   r_sh_rate, w_sh_rate;
    logic [CNT_W-1:0]    r_sh_steps, w_sh_steps;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic [PRE_W-1:0]    r_pre, w_pre;

    logic                w_hs;
    logic [FREQ_W-1:0]   w_rate_ext;
    logic [FREQ_W-1:0]   w_step_freq;
    logic                w_ovf;

    assign w_hs       = cfg_valid & r_cfg_ready;
    assign w_rate_ext = {{(FREQ_W-RATE_W){r_sh_rate[RATE_W-1]}}, r_sh_rate};

`ifdef DOPPLER_RAMP_SAT_EN
    logic [FREQ_W:0] w_sum_g;
    // Guard bit exposes signed overflow; clamp towards the overflowing side.
    assign w_sum_g     = {r_freq[FREQ_W-1], r_freq} + {w_rate_ext[FREQ_W-1], w_rate_ext};
    assign w_ovf       = w_sum_g[FREQ_W] ^ w_sum_g[FREQ_W-1];
    assign w_step_freq = !w_ovf ? w_sum_g[FREQ_W-1:0] :
                         (w_sum_g[FREQ_W] ? {1'b1, {(FREQ_W-1){1'b0}}}
                                          : {1'b0, {(FREQ_W-1){1'b1}}});
`else
    assign w_step_freq = r_freq + w_rate_ext;
    assign w_ovf       = 1'b0;
`endif

    // Next-state and next-output logic for the ramp controller.
    always_comb begin
        w_state    = r_state;
        w_freq     = r_freq;
        w_enable   = r_enable;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_sat      = r_sat;
        w_sh_freq  = r_sh_freq;
        w_sh_rate  = r_sh_rate;
        w_sh_steps = r_sh_steps;
        w_cnt      = r_cnt;
        w_pre      = r_pre;
        if (abort) begin
            w_state    = S_IDLE;
            w_freq     = {FREQ_W{1'b0}};
            w_enable   = 1'b0;
            w_busy     = 1'b0;
            w_sat      = 1'b0;
            w_sh_freq  = {FREQ_W{1'b0}};
            w_sh_rate  = {RATE_W{1'b0}};
            w_sh_steps = {CNT_W{1'b0}};
            w_cnt      = {CNT_W{1'b0}};
            w_pre      = {PRE_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        w_sh_freq  = cfg_freq;
                        w_sh_rate  = cfg_rate;
                        w_sh_steps = cfg_steps;
                        w_state    = S_LOADED;
                    end else begin
                        w_state = S_IDLE;
                    end
                end
                S_LOADED: begin
                    if (start) begin
                        w_freq   = r_sh_freq;
                        w_enable = 1'b1;
                        w_cnt    = r_sh_steps;
                        w_pre    = {PRE_W{1'b0}};
                        if (r_sh_steps == {CNT_W{1'b0}}) begin
                            w_state = S_HOLD;
                            w_done  = 1'b1;
                            w_busy  = 1'b0;
                        end else begin
                            w_state = S_RUN;
                            w_busy  = 1'b1;
                        end
                    end else if (w_hs) begin
                        w_sh_freq  = cfg_freq;
                        w_sh_rate  = cfg_rate;
                        w_sh_steps = cfg_steps;
                    end else begin
                        w_state = S_LOADED;
                    end
                end
                S_RUN: begin
                    if (r_pre == PRE_LAST) begin
                        w_pre  = {PRE_W{1'b0}};
                        w_freq = w_step_freq;
                        w_cnt  = r_cnt - CNT_W'(1);
                        w_sat  = r_sat | w_ovf;
                        if (r_cnt == CNT_W'(1)) begin
                            w_state = S_HOLD;
                            w_done  = 1'b1;
                            w_busy  = 1'b0;
                        end else begin
                            w_state = S_RUN;
                        end
                    end else begin
                        w_pre = r_pre + PRE_W'(1);
                    end
                end
                S_HOLD: begin
                    // Reload without dropping enable keeps the NCO phase continuous.
                    if (w_hs) begin
                        w_sh_freq  = cfg_freq;
                        w_sh_rate  = cfg_rate;
                        w_sh_steps = cfg_steps;
                        w_freq     = cfg_freq;
                        w_cnt      = cfg_steps;
                        w_pre      = {PRE_W{1'b0}};
                        if (cfg_steps == {CNT_W{1'b0}}) begin
                            w_done = 1'b1;
                            w_busy = 1'b0;
                        end else begin
                            w_state = S_RUN;
                            w_busy  = 1'b1;
                        end
                    end else begin
                        w_state = S_HOLD;
                    end
                end
                default: begin
                    w_state  = S_IDLE;
                    w_freq   = {FREQ_W{1'b0}};
                    w_enable = 1'b0;
                    w_busy   = 1'b0;
                end
            endcase
        end
        w_cfg_ready = (w_state != S_RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_freq      <= {FREQ_W{1'b0}};
            r_enable    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sat       <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_sh_freq   <= {FREQ_W{1'b0}};
            r_sh_rate   <= {RATE_W{1'b0}};
            r_sh_steps  <= {CNT_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_pre       <= {PRE_W{1'b0}};
        end else begin
            r_state     <= w_state;
            r_freq      <= w_freq;
            r_enable    <= w_enable;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_sat       <= w_sat;
            r_cfg_ready <= w_cfg_ready;
            r_sh_freq   <= w_sh_freq;
            r_sh_rate   <= w_sh_rate;
            r_sh_steps  <= w_sh_steps;
            r_cnt       <= w_cnt;
            r_pre       <= w_pre;
        end
    end

    assign freq      = r_freq;
    assign enable    = r_enable;
    assign busy      = r_busy;
    assign done      = r_done;
    assign sat       = r_sat;
    assign cfg_ready = r_cfg_ready;
endmodule
